// File: rtl/gpu_pkg.sv
// Shared types for the vertex front end: assembled vertex record, beat geometry, fetch FSM states.
package gpu_pkg;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } vertex_t;

  localparam int BEAT_BYTES    = 8;
  localparam int BEATS_PER_VTX = 2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} vfu_state_t;
endpackage

// File: rtl/vertex_fifo.sv
// Synchronous vertex FIFO; head is read straight from the storage registers.
module vertex_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  vertex_t                din,
  output vertex_t                dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  vertex_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/vertex_fetch_unit.sv
// Fetches a frame's vertices as 64-bit beat pairs, assembles {x,y,z}, and streams them
// out; beat0 issue is credit-gated so the FIFO always has room for every response.
module vertex_fetch_unit
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int STRIDE_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [31:0] vertex_base,
  input  logic [31:0] vertex_count,
  output logic        busy,
  output logic        done,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_ready,
  input  logic        mem_rd_valid,
  input  logic [63:0] mem_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] vertex_x,
  output logic [31:0] vertex_y,
  output logic [31:0] vertex_z
);
  localparam int RW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BEATS_PER_VTX);

  vfu_state_t    state, state_nxt;
  logic          done_nxt;
  logic [31:0]   base, count, vtx_idx, rsp_cnt, rsp_cnt_nxt;
  logic [BW-1:0] req_beat, rsp_beat;
  logic [RW-1:0] reserved, reserved_nxt, fifo_cnt;
  logic [31:0]   hold_x, hold_y;
  logic          start_ok, acc0, acc1, last_acc, rsp_live, push, pop;
  logic          can_issue, drain_done, fifo_full, fifo_empty;
  vertex_t       push_v, head;

  assign start_ok     = frame_start && !done;
  assign acc0         = mem_rd_req && mem_rd_ready && (req_beat == '0);
  assign acc1         = mem_rd_req && mem_rd_ready && (req_beat != '0);
  assign last_acc     = acc1 && (vtx_idx == count - 32'd1);
  assign rsp_live     = mem_rd_valid && (state != IDLE);
  assign push         = rsp_live && (rsp_beat != '0);
  assign pop          = out_valid && out_ready;
  assign reserved_nxt = reserved + RW'(acc0) - RW'(pop);
  assign can_issue    = reserved_nxt < RW'(FIFO_DEPTH);
  assign rsp_cnt_nxt  = rsp_cnt + 32'(push);
  // Finish on the edge where the last vertex leaves, so done lands the very next cycle.
  assign drain_done   = (state == DRAIN) && (rsp_cnt_nxt == count) &&
                        ((fifo_cnt + RW'(push) - RW'(pop)) == '0);
  assign push_v       = '{x: hold_x, y: hold_y, z: mem_rd_data[31:0]};

  assign busy      = (state != IDLE);
  assign out_valid = !fifo_empty;
  assign vertex_x  = out_valid ? head.x : '0;
  assign vertex_y  = out_valid ? head.y : '0;
  assign vertex_z  = out_valid ? head.z : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (start_ok) begin
                 if (vertex_count != '0) state_nxt = FETCH;
                 else                    done_nxt  = 1'b1;
               end
      FETCH:   if (last_acc) state_nxt = DRAIN;
      DRAIN:   if (drain_done) begin
                 state_nxt = IDLE;
                 done_nxt  = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base <= '0; count <= '0; vtx_idx <= '0; rsp_cnt <= '0;
      req_beat <= '0; rsp_beat <= '0; reserved <= '0;
      hold_x <= '0; hold_y <= '0;
      mem_rd_req <= 1'b0; mem_rd_addr <= '0;
    end else begin
      reserved <= reserved_nxt;
      if (state == IDLE) begin
        if (start_ok && vertex_count != '0) begin
          base        <= vertex_base & ~32'h7;
          count       <= vertex_count;
          vtx_idx     <= '0;
          rsp_cnt     <= '0;
          req_beat    <= '0;
          rsp_beat    <= '0;
          mem_rd_req  <= 1'b1;
          mem_rd_addr <= vertex_base & ~32'h7;
        end
      end else begin
        rsp_cnt <= rsp_cnt_nxt;
        if (rsp_live) begin
          rsp_beat <= rsp_beat + BW'(1);
          if (rsp_beat == '0) {hold_y, hold_x} <= mem_rd_data;
        end
        if (state == FETCH) begin
          if (acc0) begin
            req_beat    <= BW'(1);
            mem_rd_addr <= mem_rd_addr + 32'(BEAT_BYTES);
          end else if (acc1) begin
            req_beat <= '0;
            if (last_acc) mem_rd_req <= 1'b0;
            else begin
              // Next beat0 address is parked here even while credit holds req low.
              vtx_idx     <= vtx_idx + 32'd1;
              mem_rd_addr <= base + ((vtx_idx + 32'd1) << STRIDE_LOG2);
              mem_rd_req  <= can_issue;
            end
          end else if (!mem_rd_req) begin
            mem_rd_req <= can_issue;
          end
        end
      end
    end
  end

  vertex_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_v),
    .dout  (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  fifo_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full && !pop));
endmodule

// File: doc/vertex_fetch_unit.md
Name: vertex_fetch_unit

Overview:
Upstream neighbour of vertex_shader_hex. Gets per-frame vertex-buffer pointer and count, reads vertices from host memory in 64-bit beats, and assembles them into (x,y,z). Emits vertices on a valid/ready stream that drives the shader's vertex input. Read-ahead is bounded by a small credit-managed FIFO, so memory responses never need backpressure.

Parameters:
FIFO_DEPTH, 4, vertex FIFO entries; power of 2, >=2; also the cap on vertices reserved (in flight + buffered).
STRIDE_LOG2, 4, log2 of vertex stride in bytes; >=4 (16 B: x,y,z,pad).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
frame_start  in  1  one-cycle pulse; starts a fetch when idle
vertex_base  in  32  byte address of vertex 0; sampled on accepted frame_start; bits[2:0] treated as 0
vertex_count  in  32  vertices this frame; sampled with vertex_base
busy  out  1  high from accepted frame_start until done
done  out  1  one-cycle pulse: all vertices handed downstream
mem_rd_req  out  1  read request valid
mem_rd_addr  out  32  read byte address (8-B aligned)
mem_rd_ready  in  1  request accepted when mem_rd_req && mem_rd_ready
mem_rd_valid  in  1  read response beat, in request order, no backpressure
mem_rd_data  in  64  response data
out_valid  out  1  vertex valid to shader
out_ready  in  1  shader ready
vertex_x  out  32  vertex x (float bits, passed through)
vertex_y  out  32  vertex y
vertex_z  out  32  vertex z

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all counters 0; FIFO emptied; busy, done, mem_rd_req, out_valid = 0; mem_rd_addr and vertex_* = 0. Mid-frame reset abandons the frame. No done is produced. Responses arriving later while IDLE are dropped.
- Each vertex takes 2 beats at A = base + (i << STRIDE_LOG2), 32-bit wrap:
  - beat0 at A: x = data[31:0], y = data[63:32].
  - beat1 at A+8: z = data[31:0]; data[63:32] discarded.
- FSM IDLE -> FETCH -> DRAIN -> IDLE.
  - IDLE: frame_start with count>0 latches base/count, goes to FETCH, sets busy.
  - IDLE with count==0: done pulses the next cycle; busy stays 0; no requests issued.
  - frame_start while not IDLE is ignored.
  - FETCH: mem_rd_req rises the cycle after frame_start. Request addr/req stay stable until accepted. beat1 request always directly follows beat0 acceptance.
  - FETCH, beat0 gating: beat0 is issued only if reserved < FIFO_DEPTH. reserved += 1 on beat0 accept; reserved -= 1 on FIFO pop.
  - FETCH exit: after beat1 of vertex count-1 is accepted, mem_rd_req drops the same cycle and the FSM enters DRAIN.
  - DRAIN: waits until all responses are received and the FIFO is empty with the last vertex popped. Then done=1 for one cycle, busy=0, back to IDLE. A frame_start in that same done cycle is ignored.
- Assembly: x/y held in a holding register after beat0. Beat1 pushes {x,y,z} into the FIFO. The credit scheme guarantees the FIFO is never full on push; an assertion flags overflow.
- Output: registered FIFO head. out_valid/vertex_* stay stable while out_valid && !out_ready; pop on out_valid && out_ready.
- Latency: a beat1 response at cycle t with an empty FIFO gives out_valid at t+1.
- Throughput: 1 vertex per 2 cycles with zero-wait memory, out_ready=1, and memory latency < FIFO_DEPTH*2 cycles.
- Simultaneous push and pop: both occur in the same cycle; the count is unchanged. Simultaneous reserve and release in one cycle leave reserved unchanged.
- Counters: vertex index and response counters are 32 bits; count up to 2^32-1 is supported; addresses wrap modulo 2^32.

Decomposition:
- gpu_pkg:
  - typedef vertex_t {logic [31:0] x,y,z}
  - localparams BEAT_BYTES=8, BEATS_PER_VTX=2
  - enum vfu_state_t {IDLE,FETCH,DRAIN}
- Sub-module: vertex_fifo — generic synchronous FIFO of vertex_t with count, push/pop, full/empty, same clk/reset convention.

Test Plan:
1. base=0x1000, count=3, zero-wait memory returning data=addr-derived pattern, out_ready=1:
   - addresses 0x1000,0x1008,0x1010,0x1018,0x1020,0x1028.
   - vertices emitted in order with x=mem[A][31:0], z=mem[A+8][31:0].
   - done one cycle after the third pop; busy falls with done.
2. count=0 frame_start -> no mem_rd_req ever; done pulses exactly once, next cycle; busy stays 0.
3. count=10, out_ready=0 throughout:
   - exactly FIFO_DEPTH=4 beat0 requests accepted, then mem_rd_req stays 0.
   - after raising out_ready, all 10 vertices are delivered; FIFO never overflows.
4. Random mem_rd_ready stalls, response latency 1–6 cycles, random out_ready:
   - scoreboard matches all 64 vertices in order.
   - mem_rd_addr stable while stalled; out_* stable while stalled.
5. base=0xFFFF_FFE0, count=3 -> addresses 0xFFFFFFE0, 0xFFFFFFE8, 0xFFFFFFF0, 0xFFFFFFF8, 0x00000000, 0x00000008.
6. Reset mid-frame (count=8, after 3 vertices out):
   - all outputs 0 next cycle; no done pulse.
   - a new frame_start base=0x2000, count=2 fetches cleanly from 0x2000 with no stale vertex.
   - a second frame_start while busy is ignored.
